// File: rtl/vga_arb_pkg.sv
// Shared definitions for the VGA pixel-write arbiter.
//   SCREEN_W / SCREEN_H : visible screen size, used by the optional bounds filter
//   DEF_X_W / DEF_Y_W / DEF_C_W : default pixel coordinate and colour widths
//   arb_state_e : arbiter FSM states
package vga_arb_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam int DEF_X_W = 8;
  localparam int DEF_Y_W = 7;
  localparam int DEF_C_W = 12;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vga_write_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority selector.
//   req        in  N_REQ  request vector
//   last_grant in  GW     most recently served requester
//   winner     out GW     first requester at or after (last_grant+1) mod N_REQ
//   any        out 1      at least one request present
module rr_pick
  import vga_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last_grant,
  output logic [GW-1:0]    winner,
  output logic             any
);

  logic [GW-1:0] idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = GW'((32'(last_grant) + k) % N_REQ);
      if (!any && req[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/vga_write_arbiter.sv
// vga_write_arbiter: shares the single VGA pixel-write port among N_REQ
// producers. One producer at a time is granted (round-robin) and keeps the
// grant until it hands over its last pixel or the watchdog revokes it.
// Accepted pixels are registered once before driving the VGA adapter.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   req_valid/req_last    per-requester handshake and end-of-burst marker
//   req_x/req_y/req_color flattened pixel data, slice i = [i*W +: W]
//   req_ready             one-hot ready for the granted requester while LOCKED
//   vga_x/y/color/plot    registered pixel and one-cycle write strobe
//   grant_id              current / last granted requester
//   busy                  high while LOCKED
//   timeout_pulse         one-cycle pulse when the watchdog revokes a grant
//
// Optional feature: define VGA_ARB_BOUNDS_EN to suppress the plot strobe for
// pixels outside SCREEN_W x SCREEN_H (they are still accepted).
module vga_write_arbiter
  import vga_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int C_W     = DEF_C_W,
  parameter int TIMEOUT = 255
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0]           req_last,
  input  logic [N_REQ*X_W-1:0]       req_x,
  input  logic [N_REQ*Y_W-1:0]       req_y,
  input  logic [N_REQ*C_W-1:0]       req_color,
  output logic [N_REQ-1:0]           req_ready,
  output logic [X_W-1:0]             vga_x,
  output logic [Y_W-1:0]             vga_y,
  output logic [C_W-1:0]             vga_color,
  output logic                       vga_plot,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       timeout_pulse
);

  localparam int GW   = $clog2(N_REQ);
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Expiry is detected on the idle cycle that would bring the count to TIMEOUT.
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WD_W-1:0] WD_MAX  = '1;

  arb_state_e       state_q, state_d;
  logic [GW-1:0]    grant_q, grant_d;
  logic [GW-1:0]    last_q, last_d;
  logic [N_REQ-1:0] ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             tpulse_q, tpulse_d;
  logic             plot_q, plot_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [C_W-1:0]   color_q, color_d;
  logic [WD_W-1:0]  wd_q, wd_d;

  logic             pick_any;
  logic [GW-1:0]    pick_id;
  logic             g_valid;
  logic             g_last;
  logic [X_W-1:0]   g_x;
  logic [Y_W-1:0]   g_y;
  logic [C_W-1:0]   g_color;
  logic             in_bounds;

  rr_pick #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_rr_pick (
    .req        (req_valid),
    .last_grant (last_q),
    .winner     (pick_id),
    .any        (pick_any)
  );

  always_comb begin
    g_valid = req_valid[grant_q];
    g_last  = req_last[grant_q];
    g_x     = req_x[32'(grant_q) * X_W +: X_W];
    g_y     = req_y[32'(grant_q) * Y_W +: Y_W];
    g_color = req_color[32'(grant_q) * C_W +: C_W];
`ifdef VGA_ARB_BOUNDS_EN
    in_bounds = (int'(g_x) < SCREEN_W) && (int'(g_y) < SCREEN_H);
`else
    in_bounds = 1'b1;
`endif
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    ready_d  = ready_q;
    busy_d   = busy_q;
    tpulse_d = 1'b0;
    plot_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    color_d  = color_q;
    wd_d     = wd_q;

    case (state_q)
      IDLE: begin
        wd_d = '0;
        if (pick_any) begin
          state_d          = LOCKED;
          grant_d          = pick_id;
          ready_d          = '0;
          ready_d[pick_id] = 1'b1;
          busy_d           = 1'b1;
        end
      end

      LOCKED: begin
        // ready_q is one-hot on grant_q here, so g_valid alone is the handshake.
        if (g_valid) begin
          wd_d = '0;
          if (in_bounds) begin
            plot_d  = 1'b1;
            x_d     = g_x;
            y_d     = g_y;
            color_d = g_color;
          end
          if (g_last) begin
            state_d = IDLE;
            last_d  = grant_q;
            ready_d = '0;
            busy_d  = 1'b0;
          end
        end else if (TIMEOUT > 0) begin
          if (wd_q == WD_LAST) begin
            state_d  = IDLE;
            last_d   = grant_q;
            ready_d  = '0;
            busy_d   = 1'b0;
            tpulse_d = 1'b1;
            wd_d     = '0;
          end else if (wd_q != WD_MAX) begin
            wd_d = wd_q + 1'b1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= GW'(N_REQ - 1);
      ready_q  <= '0;
      busy_q   <= 1'b0;
      tpulse_q <= 1'b0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      color_q  <= '0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      tpulse_q <= tpulse_d;
      plot_q   <= plot_d;
      x_q      <= x_d;
      y_q      <= y_d;
      color_q  <= color_d;
      wd_q     <= wd_d;
    end
  end

  assign req_ready     = ready_q;
  assign vga_x         = x_q;
  assign vga_y         = y_q;
  assign vga_color     = color_q;
  assign vga_plot      = plot_q;
  assign grant_id      = grant_q;
  assign busy          = busy_q;
  assign timeout_pulse = tpulse_q;

endmodule

// File: tb/tb_vga_write_arbiter.sv
// Testbench for vga_write_arbiter: producer queues drive the request ports,
// a transaction-level reference model predicts grants and accepted pixels,
// and a monitor compares every plotted pixel against the expectation queue.
module tb_vga_write_arbiter;

  localparam int NR  = 4;
  localparam int XW  = 8;
  localparam int YW  = 7;
  localparam int CW  = 12;
  localparam int TMO = 4;

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
    logic          last;
    int            gap;
  } pix_t;

  typedef struct {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] c;
    int            due;
  } exp_t;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic [NR-1:0]        req_valid = '0;
  logic [NR-1:0]        req_last = '0;
  logic [NR*XW-1:0]     req_x = '0;
  logic [NR*YW-1:0]     req_y = '0;
  logic [NR*CW-1:0]     req_color = '0;
  logic [NR-1:0]        req_ready;
  logic [XW-1:0]        vga_x;
  logic [YW-1:0]        vga_y;
  logic [CW-1:0]        vga_color;
  logic                 vga_plot;
  logic [1:0]           grant_id;
  logic                 busy;
  logic                 timeout_pulse;

  vga_write_arbiter #(
    .N_REQ   (NR),
    .X_W     (XW),
    .Y_W     (YW),
    .C_W     (CW),
    .TIMEOUT (TMO)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_last      (req_last),
    .req_x         (req_x),
    .req_y         (req_y),
    .req_color     (req_color),
    .req_ready     (req_ready),
    .vga_x         (vga_x),
    .vga_y         (vga_y),
    .vga_color     (vga_color),
    .vga_plot      (vga_plot),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clock = ~clock;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  pix_t prod_q[NR][$];
  int   wait_c[NR];
  exp_t exp_q[$];
  int   n_exp = 0;
  int   n_plot = 0;
  int   n_tmo_model = 0;
  int   n_tmo_dut = 0;

  // reference model state
  bit   m_locked = 0;
  int   m_g = 0;
  int   m_last = NR - 1;
  int   m_idle = 0;
  bit   m_pulse = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit on_screen(input pix_t p);
`ifdef VGA_ARB_BOUNDS_EN
    return (p.x < 160) && (p.y < 120);
`else
    return 1'b1;
`endif
  endfunction

  function automatic pix_t mk(input int x, input int y, input int c, input bit last, input int gap);
    pix_t p;
    p.x = XW'(x);
    p.y = YW'(y);
    p.c = CW'(c);
    p.last = last;
    p.gap = gap;
    return p;
  endfunction

  task automatic drive_inputs();
    logic [NR-1:0]    v;
    logic [NR-1:0]    l;
    logic [NR*XW-1:0] xs;
    logic [NR*YW-1:0] ys;
    logic [NR*CW-1:0] cs;
    pix_t             h;
    v = '0; l = '0; xs = '0; ys = '0; cs = '0;
    for (int i = 0; i < NR; i++) begin
      if (prod_q[i].size() > 0 && wait_c[i] == 0) begin
        h = prod_q[i][0];
        v[i] = 1'b1;
        l[i] = h.last;
        xs[i*XW +: XW] = h.x;
        ys[i*YW +: YW] = h.y;
        cs[i*CW +: CW] = h.c;
      end
    end
    req_valid = v;
    req_last  = l;
    req_x     = xs;
    req_y     = ys;
    req_color = cs;
  endtask

  task automatic push_pix(input int i, input pix_t p);
    if (prod_q[i].size() == 0) wait_c[i] = p.gap;
    prod_q[i].push_back(p);
  endtask

  task automatic push_burst(input int i, input int len, input int maxgap);
    pix_t p;
    for (int k = 0; k < len; k++) begin
      p.x = XW'($urandom);
      p.y = YW'($urandom);
      p.c = CW'($urandom);
      p.last = (k == len - 1);
      p.gap = (maxgap > 0 && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, maxgap)) : 0;
      push_pix(i, p);
    end
  endtask

  // One clock edge: advance the model on the inputs presented before the
  // edge, compare the registered outputs, then let producers react.
  task automatic step();
    logic [NR-1:0] v;
    logic [NR-1:0] exp_rdy;
    int            acc;
    bit            found;
    int            c;
    pix_t          p;
    exp_t          e;
    v = req_valid;
    @(posedge clock);
    #1;
    cyc++;
    acc = -1;
    m_pulse = 0;
    if (m_locked) begin
      if (v[m_g]) begin
        acc = m_g;
        m_idle = 0;
        p = prod_q[m_g][0];
        if (on_screen(p)) begin
          e.x = p.x; e.y = p.y; e.c = p.c; e.due = cyc;
          exp_q.push_back(e);
          n_exp++;
        end
        if (p.last) begin
          m_locked = 0;
          m_last = m_g;
        end
      end else begin
        m_idle++;
        if (TMO > 0 && m_idle == TMO) begin
          m_locked = 0;
          m_last = m_g;
          m_pulse = 1;
          m_idle = 0;
          n_tmo_model++;
        end
      end
    end else begin
      m_idle = 0;
      found = 0;
      for (int k = 1; k <= NR; k++) begin
        c = (m_last + k) % NR;
        if (!found && v[c]) begin
          found = 1;
          m_g = c;
          m_locked = 1;
        end
      end
    end

    exp_rdy = '0;
    if (m_locked) exp_rdy[m_g] = 1'b1;
    chk("grant_id", 32'(grant_id), m_g);
    chk("busy", 32'(busy), 32'(m_locked));
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("timeout_pulse", 32'(timeout_pulse), 32'(m_pulse));
    if (timeout_pulse === 1'b1) n_tmo_dut++;

    for (int i = 0; i < NR; i++) begin
      if (i == acc) begin
        void'(prod_q[i].pop_front());
        if (prod_q[i].size() > 0) wait_c[i] = prod_q[i][0].gap;
      end else if (wait_c[i] > 0) begin
        wait_c[i]--;
      end
    end
    drive_inputs();
  endtask

  function automatic bit pending();
    for (int i = 0; i < NR; i++) if (prod_q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((pending() || m_locked) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: still busy after %0d cycles", name, n);
    end
    repeat (2) step();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    n_exp -= exp_q.size();
    exp_q.delete();
    for (int i = 0; i < NR; i++) begin
      prod_q[i].delete();
      wait_c[i] = 0;
    end
    drive_inputs();
    #1;
    chk("rst_vga_x", 32'(vga_x), 0);
    chk("rst_vga_y", 32'(vga_y), 0);
    chk("rst_vga_color", 32'(vga_color), 0);
    chk("rst_vga_plot", 32'(vga_plot), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_timeout_pulse", 32'(timeout_pulse), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    m_locked = 0;
    m_g = 0;
    m_last = NR - 1;
    m_idle = 0;
    m_pulse = 0;
  endtask

  // monitor: every plot strobe must match the oldest due expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        chk("plot_strobe", 32'(vga_plot), 1);
        chk("plot_x", 32'(vga_x), 32'(e.x));
        chk("plot_y", 32'(vga_y), 32'(e.y));
        chk("plot_color", 32'(vga_color), 32'(e.c));
        if (vga_plot === 1'b1) n_plot++;
      end else if (vga_plot !== 1'b0) begin
        chk("plot_spurious", 32'(vga_plot), 0);
      end
    end
  end

  initial begin
    int n;
    for (int i = 0; i < NR; i++) wait_c[i] = 0;
    #1;
    apply_reset();

    // single requester, 3-pixel burst
    push_pix(1, mk(10, 20, 'hF00, 0, 0));
    push_pix(1, mk(11, 20, 'hF00, 0, 0));
    push_pix(1, mk(12, 20, 'hF00, 1, 0));
    drive_inputs();
    drain("drain_single", 50);

    // contention from reset: 0, 2, then 0 again
    #2;
    apply_reset();
    push_pix(0, mk(1, 1, 'h00A, 0, 0));
    push_pix(0, mk(2, 1, 'h00B, 1, 0));
    push_pix(2, mk(3, 2, 'h0A0, 0, 0));
    push_pix(2, mk(4, 2, 'h0B0, 1, 0));
    push_pix(0, mk(5, 3, 'h00C, 0, 0));
    push_pix(0, mk(6, 3, 'h00D, 1, 0));
    drive_inputs();
    drain("drain_pair", 50);

    // all four requesters, single-pixel bursts, twice round
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) push_pix(i, mk(20 + i, 30 + r, 16 * i + r, 1, 0));
    drive_inputs();
    drain("drain_all4", 80);

    // watchdog: 3 idle cycles survive, 4 idle cycles revoke; requester 2 waits
    push_pix(1, mk(40, 40, 'h111, 0, 0));
    push_pix(1, mk(41, 40, 'h112, 0, TMO - 1));
    push_pix(1, mk(42, 40, 'h113, 1, TMO));
    push_pix(2, mk(50, 50, 'h222, 1, 2));
    drive_inputs();
    drain("drain_watchdog", 80);

    // screen-edge pixels
    push_pix(3, mk(160, 5, 'h333, 0, 0));
    push_pix(3, mk(159, 119, 'h334, 1, 0));
    drive_inputs();
    drain("drain_bounds", 40);

    // randomized traffic with occasional producer stalls
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < NR; i++)
        if (prod_q[i].size() < 2 && $urandom_range(0, 5) == 0)
          push_burst(i, int'($urandom_range(1, 4)), 6);
      drive_inputs();
      step();
    end
    drain("drain_random", 3000);

    // reset while locked mid-burst, then requester 0 must win
    push_burst(2, 6, 0);
    drive_inputs();
    n = 0;
    while (!(m_locked && m_g == 2) && n < 20) begin
      step();
      n++;
    end
    chk("midburst_locked", 32'(m_locked && m_g == 2), 1);
    step();
    step();
    #2;
    apply_reset();
    push_pix(3, mk(70, 70, 'h777, 1, 0));
    push_pix(0, mk(71, 71, 'h778, 1, 0));
    drive_inputs();
    step();
    chk("post_reset_winner", 32'(grant_id), 0);
    drain("drain_post_reset", 40);

    chk("exp_queue_empty", 32'(exp_q.size()), 0);
    chk("plot_count", 32'(n_plot), 32'(n_exp));
    chk("timeout_count", 32'(n_tmo_dut), 32'(n_tmo_model));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_write_arbiter.md
# vga_write_arbiter

Shares the single VGA pixel-write port among up to N_REQ pixel producers (greeting, renderer, game-over screens, future overlays). Each producer bursts pixels under a valid/ready handshake; the arbiter grants one producer at a time with round-robin fairness and holds the grant until the burst ends. A watchdog revokes stalled grants. Accepted pixels are registered once before driving the VGA adapter.

## Interface
- N_REQ, 4, number of requesters (2..8)
- X_W, 8, pixel x width
- Y_W, 7, pixel y width
- C_W, 12, colour width
- TIMEOUT, 255, idle cycles tolerated inside a granted burst; 0 disables the watchdog

- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  N_REQ  requester i presents a pixel
- req_last  in  N_REQ  presented pixel is the final pixel of the burst
- req_x  in  N_REQ*X_W  flattened; slice i = [i*X_W +: X_W]
- req_y  in  N_REQ*Y_W  flattened, same slicing
- req_color  in  N_REQ*C_W  flattened, same slicing
- req_ready  out  N_REQ  pixel of requester i accepted this cycle when valid&ready
- vga_x  out  X_W  registered pixel x
- vga_y  out  Y_W  registered pixel y
- vga_color  out  C_W  registered colour
- vga_plot  out  1  write strobe, one cycle per pixel
- grant_id  out  clog2(N_REQ)  current/last granted requester
- busy  out  1  high in LOCKED
- timeout_pulse  out  1  one-cycle pulse when the watchdog revokes a grant

## Operation
- States: IDLE, LOCKED.
- IDLE: req_ready all 0. If any req_valid is high, choose the winner by round-robin starting at (last_grant+1) mod N_REQ. Register grant_id, enter LOCKED next cycle.
- LOCKED: req_ready = one-hot(grant_id); all other bits are 0. Handshake on req_valid[g] & req_ready[g] accepts the pixel.
- An accepted pixel with req_last=1 returns to IDLE and sets last_grant = g. An accepted single-pixel burst (last on first pixel) is legal.
- Watchdog: idle counter clears on each accept and increments on each LOCKED cycle with req_valid[g]=0. When it reaches TIMEOUT, return to IDLE, pulse timeout_pulse, set last_grant = g. Requester g loses priority.
- Requests from non-granted requesters are held by the producers and never dropped. Their ready stays 0.
- After reset, last_grant = N_REQ-1, so requester 0 wins the first contention.
- Reset values: vga_x, vga_y, vga_color, vga_plot, grant_id, busy, timeout_pulse, req_ready all 0. Watchdog counter 0. State IDLE.

## Timing
- Request to first ready: 1 cycle (valid seen in IDLE at cycle n, ready high at n+1).
- Accept to plot: 1 cycle. vga_plot is high in the cycle after the handshake, with vga_x/y/color holding that pixel. Otherwise vga_plot is 0 and the data hold their last value.
- Throughput in LOCKED: 1 pixel/cycle.
- Burst end: one IDLE cycle between consecutive bursts, so minimum 1 dead cycle at each grant change.
- The last-pixel accept and the watchdog expiry cannot coincide, because the accept clears the counter.
- Reset asserted mid-burst: immediate return to IDLE, plot 0, and no partial pixel is emitted after reset deasserts.
- Watchdog counter width is clog2(TIMEOUT+1) and saturates. It is unused when TIMEOUT=0.

## Configuration
- VGA_ARB_BOUNDS_EN defined: a pixel with x ≥ SCREEN_W (160) or y ≥ SCREEN_H (120) is still accepted (ready/last/watchdog behave normally) but produces no vga_plot.
- VGA_ARB_BOUNDS_EN undefined: every accepted pixel is plotted unchanged.

## Structure
- Package vga_arb_pkg holds SCREEN_W=160, SCREEN_H=120, the default X_W/Y_W/C_W, and the state enum {IDLE, LOCKED}.
- One sub-module, rr_pick: combinational round-robin priority selector (req vector + last_grant → winner index + any). The arbiter FSM, watchdog and output register stay in vga_write_arbiter.

## Test plan
- Single requester 1, 3-pixel burst (10,20,0xF00)…(12,20,0xF00), last on third → ready at cycle+1, vga_plot high for exactly 3 consecutive cycles with matching x/y/colour, busy falls after the last accept.
- Requesters 0 and 2 both valid from reset with 2-pixel bursts → order 0, 2, then 0 again if it re-requests, with one dead cycle between bursts.
- All 4 requesters valid continuously with 1-pixel bursts → grant_id sequence 0,1,2,3,0, no requester starved.
- TIMEOUT=4, requester 1 granted then drops valid → timeout_pulse at the 4th idle cycle, state IDLE, next grant goes to requester 2 if it is waiting.
- Reset asserted while LOCKED mid-burst → all outputs 0 next edge, and requester 0 wins the next contention.
- VGA_ARB_BOUNDS_EN: pixel (160,5) then (159,119) → both accepted, only the second plotted.
